// File: rtl/hamming_enc_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// hamming_enc_pipe : 2-stage valid/ready systematic Hamming encoder with a
//                    wrapping codeword counter; HAMMING_SECDED_EN adds parity.
// Rev 1.0
// ============================================================================
module hamming_enc_pipe #(
   parameter  int DATA_W = 7,
   parameter  int CNT_W  = 16,
   localparam int PAR_W  = (DATA_W + 4   <= 8)   ? 3 :
                           (DATA_W + 5   <= 16)  ? 4 :
                           (DATA_W + 6   <= 32)  ? 5 :
                           (DATA_W + 7   <= 64)  ? 6 : 7,
`ifdef HAMMING_SECDED_EN
   localparam int CW_W   = DATA_W + PAR_W + 1
`else
   localparam int CW_W   = DATA_W + PAR_W
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW_W-1:0]   out_cw,
   output logic [CNT_W-1:0]  cw_count
);

   logic              r_s1_valid;
   logic [DATA_W-1:0] r_s1_data;
   logic              r_s2_valid;
   logic [CW_W-1:0]   r_s2_cw;
   logic [CNT_W-1:0]  r_cw_count;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_s2_load;
   logic [CW_W-1:0]   w_cw;

   // Walk Hamming positions 3,5,6,7,9,... handing each to the next data bit;
   // check bit j collects every data bit whose position has bit j set.
   function automatic logic [PAR_W-1:0] f_check_bits(input logic [DATA_W-1:0] d);
      logic [PAR_W-1:0] c;
      int               idx;
      c   = '0;
      idx = 0;
      for (int pos = 3; pos < (1 << PAR_W); pos++) begin
         if (((pos & (pos - 1)) != 0) && (idx < DATA_W)) begin
            for (int j = 0; j < PAR_W; j++) begin
               if (((pos >> j) & 1) != 0) begin
                  c[j] = c[j] ^ d[idx];
               end
            end
            idx++;
         end
      end
      return c;
   endfunction

   always_comb begin
      w_cw                        = '0;
      w_cw[DATA_W-1:0]            = r_s1_data;
      w_cw[DATA_W+PAR_W-1:DATA_W] = f_check_bits(r_s1_data);
`ifdef HAMMING_SECDED_EN
      w_cw[CW_W-1]                = ^w_cw[CW_W-2:0];
`endif
   end

   // Ready is forced high while in reset so upstream never sees a stall there.
   assign in_ready   = !reset_n || !r_s1_valid || !r_s2_valid || out_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_s2_valid && out_ready;
   assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else if (w_in_fire) begin
         r_s1_valid <= 1'b1;
         r_s1_data  <= in_data;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_s2_valid <= 1'b0;
         r_s2_cw    <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= 1'b1;
         r_s2_cw    <= w_cw;
      end else if (w_out_fire) begin
         r_s2_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cw_count <= '0;
      end else if (w_out_fire) begin
         r_cw_count <= r_cw_count + 1'b1;
      end
   end

   assign out_valid = r_s2_valid;
   assign out_cw    = r_s2_cw;
   assign cw_count  = r_cw_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_enc_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_hamming_enc_pipe : scoreboard bench for hamming_enc_pipe (both builds).
// Rev 1.0
// ============================================================================
module tb_hamming_enc_pipe;

   localparam int DATA_W = 7;
   localparam int CNT_W  = 16;
   localparam int PAR_W  = 4;
`ifdef HAMMING_SECDED_EN
   localparam int CW_W = 12;
   localparam logic [CW_W-1:0] C01 = 12'h981;
   localparam logic [CW_W-1:0] C7F = 12'hFFF;
`else
   localparam int CW_W = 11;
   localparam logic [CW_W-1:0] C01 = 11'h181;
   localparam logic [CW_W-1:0] C7F = 11'h7FF;
`endif

   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CW_W-1:0]   out_cw;
   logic [CNT_W-1:0]  cw_count;

   logic              c4_rst_n;
   logic              c4_in_valid;
   logic              c4_in_ready;
   logic [DATA_W-1:0] c4_in_data;
   logic              c4_out_valid;
   logic              c4_out_ready;
   logic [CW_W-1:0]   c4_out_cw;
   logic [3:0]        c4_cw_count;

   int                n_checks = 0;
   int                n_errors = 0;
   int                n_out    = 0;
   logic [CW_W-1:0]   exp_q[$];

   hamming_enc_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw),
      .cw_count(cw_count)
   );

   hamming_enc_pipe #(.DATA_W(DATA_W), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset_n(c4_rst_n),
      .in_valid(c4_in_valid), .in_ready(c4_in_ready), .in_data(c4_in_data),
      .out_valid(c4_out_valid), .out_ready(c4_out_ready), .out_cw(c4_out_cw),
      .cw_count(c4_cw_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: check bits are chosen so the XOR of the Hamming positions of
   // all set bits is zero, i.e. the check field equals the XOR of the
   // positions of the set data bits.
   function automatic logic [CW_W-1:0] model(input logic [DATA_W-1:0] d);
      int              pos;
      int              x;
      logic [CW_W-1:0] cw;
      pos = 2;
      x   = 0;
      for (int i = 0; i < DATA_W; i++) begin
         pos++;
         while ((pos & (pos - 1)) == 0) pos++;
         if (d[i]) x = x ^ pos;
      end
      cw                          = '0;
      cw[DATA_W-1:0]              = d;
      cw[DATA_W+PAR_W-1:DATA_W]   = x[PAR_W-1:0];
`ifdef HAMMING_SECDED_EN
      cw[CW_W-1]                  = ^cw[CW_W-2:0];
`endif
      return cw;
   endfunction

   // Input monitor: every accepted word queues its expected codeword.
   initial forever begin
      @(negedge clk);
      if (reset_n && in_valid && in_ready) exp_q.push_back(model(in_data));
   end

   // Output monitor: pops on each output handshake, also checks stall hold.
   initial begin
      logic            hold_pending;
      logic [CW_W-1:0] hold_cw;
      logic [CW_W-1:0] e;
      hold_pending = 1'b0;
      hold_cw      = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            hold_pending = 1'b0;
         end else begin
            if (hold_pending) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_cw", 32'(out_cw), 32'(hold_cw));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", 32'(out_cw), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("out_cw", 32'(out_cw), 32'(e));
                  check("cw_count_run", 32'(cw_count), 32'(n_out % 65536));
                  n_out++;
               end
            end
            hold_pending = out_valid && !out_ready;
            hold_cw      = out_cw;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      n_out = 0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic drain(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 50; cyc++) begin
         step();
         if (exp_q.size() == 0) break;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Called right after a step: offers d, checks it appears exactly 2 cycles later.
   task automatic lat_test(input logic [DATA_W-1:0] d, input logic [CW_W-1:0] exp_cw);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b1;
      @(negedge clk);
      check("lat_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_data  = 7'h5A;
      @(negedge clk);
      check("lat_1cyc_valid", 32'(out_valid), 32'd0);
      step();
      @(negedge clk);
      check("lat_2cyc_valid", 32'(out_valid), 32'd1);
      check("lat_cw", 32'(out_cw), 32'(exp_cw));
   endtask

   initial begin
      logic [DATA_W-1:0] words[3];
      int                k;
      int                sent;
      int                n4;

      reset_n      = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b0;
      c4_rst_n     = 1'b0;
      c4_in_valid  = 1'b0;
      c4_in_data   = '0;
      c4_out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_cw", 32'(out_cw), 32'd0);
      check("rst_cw_count", 32'(cw_count), 32'd0);

      // Known vectors, first one offered on the first edge after reset release
      step();
      reset_n = 1'b1;
      lat_test(7'h01, C01);
      step();
      lat_test(7'h7F, C7F);
      step();
      lat_test(7'h00, '0);
      drain("drain_vectors");
      check("count_vectors", 32'(cw_count), 32'd3);

      // Back-pressure: three words against a stalled output
      do_reset();
      words[0] = 7'h11;
      words[1] = 7'h22;
      words[2] = 7'h33;
      out_ready = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         step();
         in_valid = 1'b1;
         in_data  = words[k % 3];
         @(negedge clk);
         if (in_ready) k++;
      end
      check("stall_accepted", 32'(k), 32'd2);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_head", 32'(out_cw), 32'(model(words[0])));
      for (int cyc = 0; cyc < 10 && k < 3; cyc++) begin
         step();
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_data   = words[k % 3];
         @(negedge clk);
         if (in_ready) k++;
      end
      step();
      check("stall_all_accepted", 32'(k), 32'd3);
      drain("drain_stall");

      // Random traffic
      do_reset();
      sent = 0;
      for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
         step();
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 7'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (in_valid && in_ready) sent++;
      end
      step();
      check("random_sent", 32'(sent), 32'd1000);
      drain("drain_random");
      check("random_count", 32'(cw_count), 32'd1000);

      // Reset with both stages full
      do_reset();
      out_ready = 1'b0;
      step();
      in_valid = 1'b1;
      in_data  = 7'h2A;
      step();
      in_data  = 7'h55;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      step();
      reset_n   = 1'b0;
      out_ready = 1'b1;
      exp_q.delete();
      n_out = 0;
      step();
      reset_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_cw_count", 32'(cw_count), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      for (int cyc = 0; cyc < 3; cyc++) begin
         step();
         @(negedge clk);
         check("midrst_no_stale", 32'(out_valid), 32'd0);
      end

      // Narrow counter wrap on the CNT_W=4 instance
      step();
      c4_rst_n     = 1'b1;
      c4_in_valid  = 1'b1;
      c4_in_data   = 7'($urandom);
      c4_out_ready = 1'b1;
      n4 = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (c4_out_valid && c4_out_ready) begin
            check("c4_cw", 32'(c4_out_cw), 32'(model(c4_in_data)));
            n4++;
         end
         if (n4 >= 17) break;
      end
      check("c4_in_ready", 32'(c4_in_ready), 32'd1);
      check("c4_transfers", 32'(n4), 32'd17);
      step();
      c4_in_valid  = 1'b0;
      c4_out_ready = 1'b0;
      @(negedge clk);
      check("c4_count_wrap", 32'(c4_cw_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
